// File: rtl/cs_resolver.sv
// cs_resolver: converts a carry-save pair (carry word, sum word) into a
// binary sum, resolving CHUNK bits per clock so that no full-width carry
// chain sits in any single-cycle path. Operands arrive and the result
// leaves on valid/ready handshakes.
module cs_resolver #(
   parameter int WIDTH = 41,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_c,
   input  logic [WIDTH-1:0] in_s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   // Width of the last (possibly partial) chunk; bits above it are padding.
   localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] c_reg, s_reg;
   logic [WIDTH-1:0] sum_q, sum_nxt;
   logic             cout_q;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [CHUNK-1:0] c_chunk, s_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic             accept, last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign last      = (idx == LAST_IDX);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

   // Select the current chunk of both operands; bits beyond WIDTH stay zero.
   always_comb begin
      c_chunk = '0;
      s_chunk = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if ((i / CHUNK) == int'(idx)) begin
            c_chunk[i % CHUNK] = c_reg[i];
            s_chunk[i % CHUNK] = s_reg[i];
         end
      end
   end

   // One CHUNK-bit add with carry-in, then merge the result into the sum word.
   always_comb begin
      chunk_sum = {1'b0, c_chunk} + {1'b0, s_chunk} + {{CHUNK{1'b0}}, carry};
      sum_nxt   = sum_q;
      for (int i = 0; i < WIDTH; i++) begin
         if ((i / CHUNK) == int'(idx)) begin
            sum_nxt[i] = chunk_sum[i % CHUNK];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept in IDLE, walk the chunks in RUN, hold in DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, running carry, chunk index and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_reg  <= '0;
         s_reg  <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         carry  <= 1'b0;
         idx    <= '0;
      end else begin
         if (accept) begin
            c_reg <= in_c;
            s_reg <= in_s;
            carry <= 1'b0;
            idx   <= '0;
         end else if (state == RUN) begin
            sum_q <= sum_nxt;
            carry <= chunk_sum[CHUNK];
            if (last) begin
               // Carry out of bit WIDTH-1, not out of the padded chunk top.
               cout_q <= chunk_sum[LASTW];
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cs_resolver.sv
// Testbench for cs_resolver: table vectors on three CHUNK configurations,
// reset/backpressure sequences and a randomized run against an adder model.
module tb_cs_resolver;

   localparam int W = 41;

   typedef struct {
      logic [W-1:0] c;
      logic [W-1:0] s;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] in_c = '0;
   logic [W-1:0] in_s = '0;
   logic [2:0]   iv = '0;
   logic [2:0]   ordy = '0;
   logic [W-1:0] osum [3];
   logic         ocout [3];
   logic         ov [3];
   logic         ir [3];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   // Default configuration (CHUNK=8, six chunks).
   cs_resolver #(.WIDTH(W), .CHUNK(8)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_c(in_c), .in_s(in_s), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_sum(osum[0]), .out_cout(ocout[0]));

   // Whole word in one chunk.
   cs_resolver #(.WIDTH(W), .CHUNK(41)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_c(in_c), .in_s(in_s), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_sum(osum[1]), .out_cout(ocout[1]));

   // One bit per cycle.
   cs_resolver #(.WIDTH(W), .CHUNK(1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_c(in_c), .in_s(in_s), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out_sum(osum[2]), .out_cout(ocout[2]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction on DUT k; latency counts edges from accept to out_valid.
   task automatic do_op(input int k, input logic [W-1:0] c, input logic [W-1:0] s,
                        output logic [W-1:0] sum, output logic cout, output int lat);
      int t;
      t = 0;
      while (!ir[k] && t < 100) begin
         tick();
         t++;
      end
      chk("in_ready_wait", 64'(ir[k]), 64'd1);
      in_c  = c;
      in_s  = s;
      iv[k] = 1'b1;
      tick();
      iv[k] = 1'b0;
      lat = 0;
      while (!ov[k] && lat < 100) begin
         tick();
         lat++;
      end
      sum     = osum[k];
      cout    = ocout[k];
      ordy[k] = 1'b1;
      tick();
      ordy[k] = 1'b0;
   endtask

   vec_t          tbl [8];
   int            exp_lat [3];
   logic [W-1:0]  got_s;
   logic          got_c;
   int            lat;
   logic [W:0]    model;
   logic [W-1:0]  rc, rs;
   logic          hs, done;
   int            t;

   initial begin
      tbl[0] = '{41'h0_1234_5678_9, 41'h0, 41'h0_1234_5678_9, 1'b0};
      tbl[0].c = '0;
      tbl[0].s = 41'h0_1234_5678_9;
      tbl[1] = '{41'h000_0000_0001, 41'h1FF_FFFF_FFFF, 41'h0, 1'b1};
      tbl[2] = '{41'h1FF_FFFF_FFFF, 41'h1FF_FFFF_FFFF, 41'h1FF_FFFF_FFFE, 1'b1};
      tbl[3] = '{41'd5, 41'd7, 41'd12, 1'b0};
      tbl[4] = '{41'h0, 41'h0, 41'h0, 1'b0};
      tbl[5] = '{41'h0AA_AAAA_AAAA, 41'h155_5555_5555, 41'h1FF_FFFF_FFFF, 1'b0};
      tbl[6] = '{41'h100_0000_0000, 41'h100_0000_0000, 41'h0, 1'b1};
      tbl[7] = '{41'h0FF, 41'h001, 41'h100, 1'b0};
      exp_lat[0] = 6;
      exp_lat[1] = 1;
      exp_lat[2] = 41;

      // Reset state
      #2;
      chk("rst_in_ready", 64'(ir[0]), 64'd1);
      chk("rst_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_out_sum", 64'(osum[0]), 64'd0);
      chk("rst_out_cout", 64'(ocout[0]), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Table vectors on all three configurations
      for (int k = 0; k < 3; k++) begin
         for (int v = 0; v < 8; v++) begin
            do_op(k, tbl[v].c, tbl[v].s, got_s, got_c, lat);
            chk($sformatf("tbl%0d_k%0d_sum", v, k), 64'(got_s), 64'(tbl[v].exp_sum));
            chk($sformatf("tbl%0d_k%0d_cout", v, k), 64'(got_c), 64'(tbl[v].exp_cout));
            chk($sformatf("tbl%0d_k%0d_lat", v, k), 64'(lat), 64'(exp_lat[k]));
         end
      end

      // Asynchronous reset while holding a result in DONE
      in_c = tbl[2].c;
      in_s = tbl[2].s;
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (6) tick();
      chk("pre_arst_valid", 64'(ov[0]), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 64'(ir[0]), 64'd1);
      chk("arst_out_valid", 64'(ov[0]), 64'd0);
      chk("arst_out_sum", 64'(osum[0]), 64'd0);
      chk("arst_out_cout", 64'(ocout[0]), 64'd0);
      tick();
      tick();
      chk("arst_hold_sum", 64'(osum[0]), 64'd0);
      chk("arst_hold_valid", 64'(ov[0]), 64'd0);
      rst_n = 1'b1;
      tick();

      // Backpressure: stall 10 cycles in DONE with in_valid pulses
      in_c = tbl[2].c;
      in_s = tbl[2].s;
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (6) tick();
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 64'(ov[0]), 64'd1);
         chk("bp_sum", 64'(osum[0]), 64'(tbl[2].exp_sum));
         chk("bp_cout", 64'(ocout[0]), 64'd1);
         chk("bp_in_ready", 64'(ir[0]), 64'd0);
         if (i == 3 || i == 4) begin
            in_c = 41'd3;
            in_s = 41'd4;
            iv[0] = 1'b1;
         end else begin
            iv[0] = 1'b0;
         end
         tick();
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      tick();
      ordy[0] = 1'b0;
      chk("bp_release_valid", 64'(ov[0]), 64'd0);
      chk("bp_release_ready", 64'(ir[0]), 64'd1);
      repeat (3) tick();
      chk("bp_no_capture", 64'(ov[0]), 64'd0);

      // Reset mid-RUN at idx=3, then a fresh operation
      in_c = tbl[2].c;
      in_s = tbl[2].s;
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(ov[0]), 64'd0);
      chk("mid_rst_ready", 64'(ir[0]), 64'd1);
      chk("mid_rst_sum", 64'(osum[0]), 64'd0);
      chk("mid_rst_cout", 64'(ocout[0]), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      do_op(0, 41'd5, 41'd7, got_s, got_c, lat);
      chk("post_rst_sum", 64'(got_s), 64'd12);
      chk("post_rst_cout", 64'(got_c), 64'd0);
      chk("post_rst_lat", 64'(lat), 64'd6);

      // Random operands with random out_ready stalls
      for (int n = 0; n < 1000; n++) begin
         rc = W'({$urandom, $urandom});
         rs = W'({$urandom, $urandom});
         model = {1'b0, rc} + {1'b0, rs};
         t = 0;
         while (!ir[0] && t < 100) begin
            tick();
            t++;
         end
         in_c = rc;
         in_s = rs;
         iv[0] = 1'b1;
         tick();
         iv[0] = 1'b0;
         got_s = '0;
         got_c = 1'b0;
         done = 1'b0;
         t = 0;
         while (!done && t < 400) begin
            if (ov[0]) begin
               got_s = osum[0];
               got_c = ocout[0];
            end
            ordy[0] = 1'($urandom_range(0, 1));
            hs = ov[0] && ordy[0];
            tick();
            t++;
            if (hs) done = 1'b1;
         end
         ordy[0] = 1'b0;
         chk("rand_done", 64'(done), 64'd1);
         chk($sformatf("rand%0d", n), 64'({got_c, got_s}), 64'(model));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
